word_mem: RTL and testbench

- Synchronous, byte-strobed, word-organised 32-bit memory model.
- Used as both instruction memory and data memory next to the cpu core in the simulation top level.
- Contents are preloaded from hex files by hierarchical reference to the storage array, which must be named `mem`.
- A single-cycle-latency request/ack interface serves reads and byte-masked writes.

---
 rtl/word_mem.sv | 82 ++++++++
 tb/tb_word_mem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/word_mem.sv
`default_nettype none
// ============================================================================
// Module   : word_mem
// Purpose  : Synchronous, byte-strobed, word-organised 32-bit memory model.
//            Serves as instruction or data memory beside the cpu core in the
//            simulation top level. Contents are preloaded from hex files by
//            hierarchical reference to the storage array `mem`.
// Ports    : clk     - clock, all state changes on the rising edge
//            rst_n   - asynchronous active-low reset (clears resp/ack only)
//            r_v     - read request valid
//            w_v     - write request valid
//            adr     - byte address; adr[1:0] and bits above the index ignored
//            data    - write data, little-endian byte lanes
//            strobe  - byte-lane write enables, bit i -> data[8i+7:8i]
//            resp    - registered read data, valid the cycle after a read
//            ack     - one-cycle completion pulse per request cycle
// Revision : 1.0 - initial release
// ============================================================================
module word_mem #(
    parameter int XLEN  = 32,      // only 32 is supported
    parameter int DEPTH = 16384    // words; must be a power of two
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [XLEN-1:0] adr,
    input  logic [XLEN-1:0] data,
    input  logic [3:0]      strobe,
    output logic [XLEN-1:0] resp,
    output logic            ack
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_LANES = XLEN / 8;

    // Storage. Name is fixed: simulation top levels preload it by hierarchy.
    logic [XLEN-1:0] mem [0:DEPTH-1];

    // Word index: the byte offset is dropped and any address bits above the
    // index are discarded, so accesses wrap modulo DEPTH*4 bytes.
    logic [c_IDX_W-1:0] w_idx;
    assign w_idx = adr[c_IDX_W+1:2];

    // Byte offset and the bits above the index carry no meaning here.
    logic w_unused_adr;
    assign w_unused_adr = ^{adr[1:0], adr[XLEN-1:c_IDX_W+2]};

    // ------------------------------------------------------------------------
    // Storage write port. Kept outside the reset domain so that reset never
    // disturbs preloaded contents; writes presented while rst_n is low are
    // dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_v) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (strobe[i]) begin
                    mem[w_idx][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response path. The read samples `mem` with the same edge that commits a
    // concurrent write, so a read/write collision returns the pre-write word.
    // resp holds on write-only and idle cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= r_v | w_v;
            if (r_v) begin
                resp <= mem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_word_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_mem
// Purpose  : Self-checking bench for word_mem. A table of directed vectors
//            (inputs plus hand-computed resp/ack) is applied one per cycle,
//            followed by hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_mem;

    localparam int c_DEPTH = 16384;
    localparam int c_NVEC  = 20;

    logic        clk;
    logic        rst_n;
    logic        r_v;
    logic        w_v;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic [31:0] resp;
    logic        ack;

    int total;
    int bad;

    typedef struct {
        logic        r_v;
        logic        w_v;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic [31:0] exp_resp;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [c_NVEC];

    word_mem #(
        .XLEN  (32),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .r_v    (r_v),
        .w_v    (w_v),
        .adr    (adr),
        .data   (data),
        .strobe (strobe),
        .resp   (resp),
        .ack    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        r_v    = 1'b0;
        w_v    = 1'b0;
        adr    = '0;
        data   = '0;
        strobe = '0;

        //          r_v   w_v   adr                   data          strobe   resp          ack
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010,        32'h0,        4'b0000, 32'hDEADBEEF, 1'b1}; // preload survives reset
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010,        32'h12345678, 4'b1111, 32'hDEADBEEF, 1'b1}; // write: resp holds
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010,        32'h0,        4'b0000, 32'h12345678, 1'b1}; // write->read back-to-back
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010,        32'hAABBCCDD, 4'b0101, 32'h12345678, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010,        32'h0,        4'b0000, 32'h12BB56DD, 1'b1}; // lanes 0,2 only
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010,        32'hFFFFFFFF, 4'b0000, 32'h12BB56DD, 1'b1}; // empty strobe acks
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0013,        32'h0,        4'b0000, 32'h12BB56DD, 1'b1}; // misaligned
        vecs[7]  = '{1'b1, 1'b0, c_DEPTH*4 + 32'h10,   32'h0,        4'b0000, 32'h12BB56DD, 1'b1}; // wrap
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0020,        32'h22222222, 4'b1111, 32'h11111111, 1'b1}; // read-before-write
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020,        32'h0,        4'b0000, 32'h22222222, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0000,        32'h0,        4'b0000, 32'hA0A0A0A0, 1'b1}; // streaming
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0004,        32'h0,        4'b0000, 32'hA1A1A1A1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0008,        32'h0,        4'b0000, 32'hA2A2A2A2, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0010,        32'h0,        4'b0000, 32'hA2A2A2A2, 1'b0}; // idle x3
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0020,        32'h0,        4'b0000, 32'hA2A2A2A2, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0000_0004,        32'h0,        4'b1111, 32'hA2A2A2A2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h0000_0024,        32'h5A000000, 4'b1000, 32'hA2A2A2A2, 1'b1}; // top lane
        vecs[17] = '{1'b1, 1'b0, 32'h0000_0024,        32'h0,        4'b0000, 32'h5A333333, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 32'h0000_0026,        32'h0000C300, 4'b0010, 32'h5A333333, 1'b1}; // lane 1
        vecs[19] = '{1'b1, 1'b0, 32'h0000_0024,        32'h0,        4'b0000, 32'h5A33C333, 1'b1};

        // Preload before reset so that survival across reset is exercised.
        #1;
        dut.mem[0] = 32'hA0A0A0A0;
        dut.mem[1] = 32'hA1A1A1A1;
        dut.mem[2] = 32'hA2A2A2A2;
        dut.mem[4] = 32'hDEADBEEF;
        dut.mem[8] = 32'h11111111;
        dut.mem[9] = 32'h33333333;

        // Reset state while rst_n is held low from time zero.
        @(posedge clk);
        #1;
        check32("reset resp", resp, 32'h0);
        check1 ("reset ack",  ack,  1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            r_v    = vecs[i].r_v;
            w_v    = vecs[i].w_v;
            adr    = vecs[i].adr;
            data   = vecs[i].data;
            strobe = vecs[i].strobe;
            @(posedge clk);
            #1;
            check32($sformatf("vec%0d resp", i), resp, vecs[i].exp_resp);
            check1 ($sformatf("vec%0d ack",  i), ack,  vecs[i].exp_ack);
        end

        // Mid-cycle asynchronous reset: outputs clear without waiting for a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("async reset resp", resp, 32'h0);
        check1 ("async reset ack",  ack,  1'b0);

        // A full-word write presented across an edge while in reset must be dropped.
        @(negedge clk);
        r_v    = 1'b1;
        w_v    = 1'b1;
        adr    = 32'h0000_0010;
        data   = 32'h00000000;
        strobe = 4'b1111;
        @(posedge clk);
        #1;
        check32("in-reset resp", resp, 32'h0);
        check1 ("in-reset ack",  ack,  1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        w_v   = 1'b0;
        r_v   = 1'b1;
        adr   = 32'h0000_0010;
        @(posedge clk);
        #1;
        check32("post-reset read resp", resp, 32'h12BB56DD);
        check1 ("post-reset read ack",  ack,  1'b1);

        // Request ending: ack must drop on the following idle cycle.
        @(negedge clk);
        r_v = 1'b0;
        @(posedge clk);
        #1;
        check1 ("ack drop", ack, 1'b0);
        check32("idle hold", resp, 32'h12BB56DD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
